fir_mse_monitor: RTL and testbench

Output-side consumer for the FIR datapath. It accepts paired sample streams: y_ref from the exact-adder FIR and y_apx from the approximate-adder FIR. Over a window of N = 2^LOG2_N accepted pairs it accumulates the squared error and tracks the peak absolute error. At the end of the window it reports the sum of squared errors (SSE), the mean squared error (MSE) and the peak error, then pulses done. It is the metric endpoint of the approximate-circuit MSE evaluation flow.

---
 rtl/fir_mse_monitor.sv | 120 ++++++++++++
 tb/tb_fir_mse_monitor.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mse_monitor.sv
// +--------------------------------------------------------------------------+
// | fir_mse_monitor: windowed SSE / MSE / peak-error monitor that compares   |
// | exact and approximate FIR output streams.   Revision: 1.0                |
// +--------------------------------------------------------------------------+
`default_nettype none

module fir_mse_monitor #(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [DATA_W-1:0]       y_ref,
  input  logic signed [DATA_W-1:0]       y_apx,
  output logic                           busy,
  output logic                           done,
  output logic [2*DATA_W+LOG2_N-1:0]     sse,
  output logic [2*DATA_W-1:0]            mse,
  output logic [DATA_W:0]                err_max
);

  localparam int SSE_W = 2*DATA_W + LOG2_N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [LOG2_N-1:0]   cnt;
  logic                accept;
  logic                clear;
  logic                v1;
  logic                v2;
  logic [DATA_W:0]     diff1;
  logic [DATA_W:0]     abs1;
  logic [2*DATA_W-1:0] abs_w;
  logic [2*DATA_W-1:0] sq2;
  logic [DATA_W:0]     absd2;

  assign accept = in_valid && in_ready;
  assign clear  = (state == IDLE) && start;
  assign mse    = sse[SSE_W-1:LOG2_N];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN: begin
        in_ready = 1'b1;
        // the counter is all ones exactly when this accept is the Nth
        if (in_valid && (&cnt)) state_nxt = DRAIN;
      end
      DRAIN:   if (!v1 && !v2) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // |y_ref - y_apx| never exceeds 2^DATA_W - 1, so the low DATA_W bits suffice for squaring
  assign abs1  = diff1[DATA_W] ? (~diff1 + 1'b1) : diff1;
  assign abs_w = {{DATA_W{1'b0}}, abs1[DATA_W-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      diff1   <= '0;
      sq2     <= '0;
      absd2   <= '0;
      sse     <= '0;
      err_max <= '0;
    end else if (clear) begin
      cnt     <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      sse     <= '0;
      err_max <= '0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      if (accept) begin
        cnt   <= cnt + 1'b1;
        diff1 <= {y_ref[DATA_W-1], y_ref} - {y_apx[DATA_W-1], y_apx};
      end
      if (v1) begin
        sq2   <= abs_w * abs_w;
        absd2 <= abs1;
      end
      if (v2) begin
        sse <= sse + {{LOG2_N{1'b0}}, sq2};
        if (absd2 > err_max) err_max <= absd2;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_mse_monitor.sv
// Testbench for fir_mse_monitor with a 4-pair window, checked against a
// plain-arithmetic model of the measurement.
`default_nettype none

module tb_fir_mse_monitor;

  localparam int DW = 16;
  localparam int LG = 2;
  localparam int N  = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] y_ref = '0;
  logic signed [15:0] y_apx = '0;
  logic               busy;
  logic               done;
  logic [33:0]        sse;
  logic [31:0]        mse;
  logic [16:0]        err_max;

  fir_mse_monitor #(.DATA_W(DW), .LOG2_N(LG)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .y_ref(y_ref), .y_apx(y_apx), .busy(busy), .done(done),
    .sse(sse), .mse(mse), .err_max(err_max)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    bit st;
    bit v;
    int r;
    int a;
  } offer_t;

  offer_t offers[$];
  bit     obs_ready[$];
  bit     exp_ready[$];
  int     start_edge, done_cnt, done_edge, busy_after, obs_err;
  bit     prev_done;
  longint obs_sse, obs_mse;
  longint exp_sse;
  int     exp_err, exp_done_edge;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (prev_done) busy_after = busy;
    prev_done = done;
    if (done) begin
      done_cnt++;
      done_edge = cyc;
      obs_sse   = sse;
      obs_mse   = mse;
      obs_err   = err_max;
    end
  endtask

  task automatic add(input bit st, input bit v, input int r, input int a);
    offer_t o;
    o.st = st; o.v = v; o.r = r; o.a = a;
    offers.push_back(o);
  endtask

  // Pulses start, presents one offer per cycle, then idles long enough for done.
  task automatic run_offers();
    done_cnt = 0; done_edge = -1; busy_after = -1; prev_done = 1'b0;
    obs_sse = -1; obs_mse = -1; obs_err = -1;
    obs_ready.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    start_edge = cyc;
    foreach (offers[i]) begin
      start    = offers[i].st;
      in_valid = offers[i].v;
      y_ref    = 16'(offers[i].r);
      y_apx    = 16'(offers[i].a);
      obs_ready.push_back(in_ready);
      tick();
    end
    start = 1'b0;
    in_valid = 1'b0;
    repeat (12) tick();
  endtask

  // Reference: the first N valid offers after start form the window.
  task automatic predict();
    int k = 0;
    int d;
    exp_sse = 0; exp_err = 0; exp_done_edge = -2;
    exp_ready.delete();
    foreach (offers[i]) begin
      exp_ready.push_back(k < N);
      if (offers[i].v && k < N) begin
        d = offers[i].r - offers[i].a;
        exp_sse += longint'(d) * longint'(d);
        if (d < 0) d = -d;
        if (d > exp_err) exp_err = d;
        k++;
        if (k == N) exp_done_edge = start_edge + i + 4;
      end
    end
  endtask

  function automatic int ready_diffs();
    int nd = 0;
    foreach (exp_ready[i]) if (i >= obs_ready.size() || obs_ready[i] !== exp_ready[i]) nd++;
    return nd;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) begin
      tick();
      compared++;
      if ({in_ready, busy, done} !== 3'b000 || sse !== 0 || mse !== 0 || err_max !== 0) begin
        mismatched++;
        $display("FAIL reset_idle: ready=%0b busy=%0b done=%0b sse=%0d mse=%0d err=%0d, required all 0",
                 in_ready, busy, done, sse, mse, err_max);
      end
    end
  endtask

  task automatic test_zero_error();
    offers.delete();
    repeat (4) add(0, 1, 1234, 1234);
    run_offers(); predict();
    compared++;
    if (done_cnt !== 1) begin mismatched++; $display("FAIL zero_done_count: got %0d required 1", done_cnt); end
    compared++;
    if (done_edge !== exp_done_edge) begin mismatched++; $display("FAIL zero_done_timing: got edge %0d required %0d", done_edge, exp_done_edge); end
    compared++;
    if (obs_sse !== 0 || obs_mse !== 0 || obs_err !== 0) begin
      mismatched++; $display("FAIL zero_results: sse=%0d mse=%0d err=%0d required 0", obs_sse, obs_mse, obs_err);
    end
    compared++;
    if (busy_after !== 0) begin mismatched++; $display("FAIL zero_busy_after_done: got %0d required 0", busy_after); end
  endtask

  task automatic test_small_diffs();
    offers.delete();
    add(0, 1, 100, 99); add(0, 1, 100, 102); add(0, 1, 100, 97); add(0, 1, 100, 104);
    run_offers(); predict();
    compared++;
    if (obs_sse !== 30 || obs_sse !== exp_sse) begin mismatched++; $display("FAIL small_sse: got %0d required 30", obs_sse); end
    compared++;
    if (obs_mse !== 7) begin mismatched++; $display("FAIL small_mse: got %0d required 7", obs_mse); end
    compared++;
    if (obs_err !== 4) begin mismatched++; $display("FAIL small_err_max: got %0d required 4", obs_err); end
    compared++;
    if (done_cnt !== 1) begin mismatched++; $display("FAIL small_done_count: got %0d required 1", done_cnt); end
  endtask

  task automatic test_extreme();
    offers.delete();
    repeat (4) add(0, 1, 32767, -32768);
    run_offers(); predict();
    compared++;
    if (obs_sse !== 64'd17179344900) begin mismatched++; $display("FAIL extreme_sse: got %0d required 17179344900", obs_sse); end
    compared++;
    if (obs_mse !== 64'd4294836225) begin mismatched++; $display("FAIL extreme_mse: got %0d required 4294836225", obs_mse); end
    compared++;
    if (obs_err !== 65535) begin mismatched++; $display("FAIL extreme_err_max: got %0d required 65535", obs_err); end
  endtask

  task automatic test_hold();
    repeat (5) tick();
    compared++;
    if (sse !== 34'(exp_sse) || err_max !== 17'(exp_err)) begin
      mismatched++; $display("FAIL hold_results: sse=%0d err=%0d required %0d %0d", sse, err_max, exp_sse, exp_err);
    end
  endtask

  task automatic test_backpressure();
    offers.delete();
    add(0, 1, 10, 9); add(0, 0, 0, 0); add(0, 0, 0, 0); add(0, 1, 10, 12);
    add(0, 1, 10, 7); add(0, 0, 0, 0); add(0, 1, 10, 14); add(0, 1, 10, 5); add(0, 1, 10, 4);
    run_offers(); predict();
    compared++;
    if (obs_sse !== 30) begin mismatched++; $display("FAIL bp_sse: got %0d required 30", obs_sse); end
    compared++;
    if (obs_err !== 4) begin mismatched++; $display("FAIL bp_err_max: got %0d required 4", obs_err); end
    compared++;
    if (ready_diffs() !== 0) begin mismatched++; $display("FAIL bp_ready_pattern: %0d cycles differ, required 0", ready_diffs()); end
    compared++;
    if (done_edge !== exp_done_edge) begin mismatched++; $display("FAIL bp_done_timing: got edge %0d required %0d", done_edge, exp_done_edge); end
  endtask

  task automatic test_start_in_run();
    offers.delete();
    add(0, 1, 50, 45); add(1, 1, -50, 45); add(1, 0, 0, 0); add(0, 1, 7, 7); add(1, 1, -3, 3);
    run_offers(); predict();
    compared++;
    if (obs_sse !== exp_sse) begin mismatched++; $display("FAIL start_run_sse: got %0d required %0d", obs_sse, exp_sse); end
    compared++;
    if (done_edge !== exp_done_edge) begin mismatched++; $display("FAIL start_run_done_timing: got edge %0d required %0d", done_edge, exp_done_edge); end
  endtask

  task automatic test_reset_mid_window();
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; y_ref = 16'sd1000; y_apx = -16'sd1000;
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    compared++;
    if ({in_ready, busy, done} !== 3'b000 || sse !== 0 || mse !== 0 || err_max !== 0) begin
      mismatched++;
      $display("FAIL midreset_clear: ready=%0b busy=%0b done=%0b sse=%0d mse=%0d err=%0d, required all 0",
               in_ready, busy, done, sse, mse, err_max);
    end
    repeat (3) tick();
    compared++;
    if (busy !== 1'b0 || sse !== 0) begin mismatched++; $display("FAIL midreset_stays_idle: busy=%0b sse=%0d required 0 0", busy, sse); end
    in_valid = 1'b0;
    offers.delete();
    add(0, 1, 300, -200); add(0, 1, -7, 9); add(0, 1, 0, 1); add(0, 1, 1000, 999);
    run_offers(); predict();
    compared++;
    if (obs_sse !== exp_sse || obs_mse !== (exp_sse >> LG) || obs_err !== exp_err) begin
      mismatched++;
      $display("FAIL midreset_fresh_window: sse=%0d mse=%0d err=%0d required %0d %0d %0d",
               obs_sse, obs_mse, obs_err, exp_sse, exp_sse >> LG, exp_err);
    end
  endtask

  task automatic test_random();
    int nv;
    int r;
    for (int w = 0; w < 8; w++) begin
      offers.delete();
      nv = 0;
      while (nv < N + 2) begin
        offer_t o;
        o.v  = ($urandom_range(0, 9) < 7);
        o.st = ($urandom_range(0, 9) == 0);
        r    = int'($urandom_range(0, 65535)) - 32768;
        o.r  = r;
        o.a  = (w % 2 == 0) ? int'($urandom_range(0, 65535)) - 32768
                            : ((r > 32000 || r < -32000) ? r : r + int'($urandom_range(0, 40)) - 20);
        offers.push_back(o);
        if (o.v) nv++;
      end
      run_offers(); predict();
      compared++;
      if (obs_sse !== exp_sse) begin mismatched++; $display("FAIL rand%0d_sse: got %0d required %0d", w, obs_sse, exp_sse); end
      compared++;
      if (obs_mse !== (exp_sse >> LG)) begin mismatched++; $display("FAIL rand%0d_mse: got %0d required %0d", w, obs_mse, exp_sse >> LG); end
      compared++;
      if (obs_err !== exp_err) begin mismatched++; $display("FAIL rand%0d_err_max: got %0d required %0d", w, obs_err, exp_err); end
      compared++;
      if (done_cnt !== 1 || done_edge !== exp_done_edge) begin
        mismatched++; $display("FAIL rand%0d_done: count %0d edge %0d required 1 %0d", w, done_cnt, done_edge, exp_done_edge);
      end
      compared++;
      if (ready_diffs() !== 0) begin mismatched++; $display("FAIL rand%0d_ready_pattern: %0d cycles differ, required 0", w, ready_diffs()); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_error();
    test_small_diffs();
    test_extreme();
    test_hold();
    test_backpressure();
    test_start_in_run();
    test_reset_mid_window();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
